// File: rtl/mips_avalon_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the instruction-fetch and
// data-access ports of a Harvard core; read data is forwarded to the owner of the transfer.
module mips_avalon_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    // instruction requester
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_waitrequest,
    // data requester
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W/8-1:0] d_byteenable,
    input  logic [DATA_W-1:0]   d_writedata,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_waitrequest,
    // bus master side
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                waitrequest,
    output logic                busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic              d_req;
    logic              i_done, d_done;

    assign d_req  = d_read | d_write;
    assign i_done = (state_q == GRANT_I) && !waitrequest;
    assign d_done = (state_q == GRANT_D) && !waitrequest;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                // On a tie, the side that did not win last time goes first.
                if (i_read && d_req) begin
                    state_d = last_d_q ? GRANT_I : GRANT_D;
                end else if (i_read) begin
                    state_d = GRANT_I;
                end else if (d_req) begin
                    state_d = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!waitrequest) begin
                    state_d  = IDLE;
                    last_d_d = (state_q == GRANT_D);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            if (i_done) i_rdata_q <= readdata;
            if (d_done) d_rdata_q <= readdata;
        end
    end

    always_comb begin
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        byteenable = '0;
        writedata  = '0;
        case (state_q)
            GRANT_I: begin
                address    = i_address;
                read       = 1'b1;
                byteenable = '1;
            end
            GRANT_D: begin
                address    = d_address;
                // Illegal read+write is treated as a write.
                read       = d_read & ~d_write;
                write      = d_write;
                byteenable = d_byteenable;
                writedata  = d_writedata;
            end
            default: ;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign i_waitrequest = !i_done;
    assign d_waitrequest = !d_done;
    assign i_readdata    = i_done ? readdata : i_rdata_q;
    assign d_readdata    = d_done ? readdata : d_rdata_q;

endmodule
